// File: rtl/dma_write_pkg.sv
`default_nettype none
// ==== dma_write_pkg : shared constants and types for dma_write_ctrl (rev 1.0) ====
package dma_write_pkg;

  localparam int         BEAT_BYTES = 64;
  localparam int         MAX_BURST  = 64;
  localparam int         LEN_W      = 8;
  localparam logic [2:0] AXSIZE_64B = 3'd6;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // AXI length field is beats-1; this recovers the beat count without overflow.
  function automatic logic [LEN_W:0] burst_beats(input logic [LEN_W-1:0] len);
    return {1'b0, len} + {{LEN_W{1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_write_ctrl_if.sv
`default_nettype none
// ==== dma_write_ctrl_if : AXI4 write-channel bundle (AW/W/B) (rev 1.0) ====
interface dma_write_ctrl_if #(
  parameter int ADDR_W = 64
);

  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [511:0]      wdata;
  logic [63:0]       wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface
`default_nettype wire

// File: rtl/dma_write_ctrl_sync_fifo.sv
`default_nettype none
// ==== sync_fifo : first-word-fall-through FIFO with registered count (rev 1.0) ====
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (count_q == (PTR_W+1)'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    pop_data = mem_q[rd_ptr_q];
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset so the data FIFO can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/dma_write_ctrl.sv
`default_nettype none
// ==== dma_write_ctrl : buffers 512-bit beats and issues AXI4 write bursts (rev 1.0) ====
module dma_write_ctrl
  import dma_write_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int FIFO_DEPTH = 128,
  parameter int LEN_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              page_finish,
  input  logic [511:0]      in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  dma_write_ctrl_if.master  axi,
  output logic              page_done,
  output logic              wr_error
);

  state_e            state_q, state_d;
  logic [6:0]        beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] aw_ptr_q, aw_ptr_d;
  logic [15:0]       outstanding_q, outstanding_d;
  logic [7:0]        w_beat_q, w_beat_d;
  logic              wr_error_q, wr_error_d;

  logic              accept;
  logic              len_push;
  logic [7:0]        close_len;
  logic              aw_hs, w_hs, b_hs;
  logic              len_full;
  logic              fifos_empty;

  logic [511:0]                    data_head;
  logic                            data_full, data_empty;
  logic [$clog2(FIFO_DEPTH):0]     data_count;
  logic [7:0]                      aw_len_head, w_len_head;
  logic                            aw_len_full, aw_len_empty;
  logic                            w_len_full, w_len_empty;
  logic [$clog2(LEN_DEPTH):0]      aw_len_count, w_len_count;

  sync_fifo #(.WIDTH(512), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(accept), .push_data(in_data),
    .pop(w_hs), .pop_data(data_head),
    .full(data_full), .empty(data_empty), .count(data_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(LEN_DEPTH)) u_aw_len_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(len_push), .push_data(close_len),
    .pop(aw_hs), .pop_data(aw_len_head),
    .full(aw_len_full), .empty(aw_len_empty), .count(aw_len_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(LEN_DEPTH)) u_w_len_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(len_push), .push_data(close_len),
    .pop(w_hs & axi.wlast), .pop_data(w_len_head),
    .full(w_len_full), .empty(w_len_empty), .count(w_len_count)
  );

  // Valids depend only on registered FIFO state, never on the ready inputs.
  assign axi.awvalid = ~aw_len_empty;
  assign axi.awaddr  = aw_ptr_q;
  assign axi.awlen   = aw_len_empty ? 8'd0 : aw_len_head;
  assign axi.awsize  = AXSIZE_64B;
  assign axi.awburst = BURST_INCR;
  assign axi.wvalid  = ~w_len_empty & ~data_empty;
  assign axi.wdata   = data_head;
  assign axi.wstrb   = '1;
  assign axi.wlast   = axi.wvalid & (w_beat_q == w_len_head);
  assign axi.bready  = 1'b1;

  assign page_done = (state_q == ST_DONE);
  assign wr_error  = wr_error_q;

  always_comb begin
    len_full    = aw_len_full | w_len_full;
    in_ready    = (state_q == ST_RUN) & ~data_full & ~len_full;
    accept      = in_valid & in_ready;
    aw_hs       = axi.awvalid & axi.awready;
    w_hs        = axi.wvalid & axi.wready;
    b_hs        = axi.bvalid & axi.bready;
    fifos_empty = (data_count == '0) & (aw_len_count == '0) & (w_len_count == '0);

    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    aw_ptr_d      = aw_ptr_q;
    outstanding_d = outstanding_q;
    w_beat_d      = w_beat_q;
    wr_error_d    = wr_error_q;
    len_push      = 1'b0;
    close_len     = 8'd0;

    if (aw_hs) begin
      aw_ptr_d = aw_ptr_q + (ADDR_W'(burst_beats(axi.awlen)) << $clog2(BEAT_BYTES));
    end
    if (aw_hs && !b_hs) begin
      outstanding_d = outstanding_q + 16'd1;
    end else if (!aw_hs && b_hs && outstanding_q != 16'd0) begin
      outstanding_d = outstanding_q - 16'd1;
    end
    if (w_hs) begin
      w_beat_d = axi.wlast ? 8'd0 : w_beat_q + 8'd1;
    end
    if (b_hs && axi.bresp != RESP_OKAY) begin
      wr_error_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_RUN;
          aw_ptr_d      = dest_addr;
          beat_cnt_d    = 7'd0;
          outstanding_d = 16'd0;
          wr_error_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (in_last || beat_cnt_q == 7'(MAX_BURST - 1)) begin
            len_push   = 1'b1;
            close_len  = {1'b0, beat_cnt_q};
            beat_cnt_d = 7'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 7'd1;
          end
        end else if (page_finish && beat_cnt_q != 7'd0 && !len_full) begin
          // Partial trailing burst once the producer declares the page over.
          len_push   = 1'b1;
          close_len  = {1'b0, beat_cnt_q - 7'd1};
          beat_cnt_d = 7'd0;
        end
        if (page_finish && beat_cnt_q == 7'd0 && fifos_empty && outstanding_q == 16'd0 &&
            !aw_hs && !axi.bvalid && !accept) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= 7'd0;
      aw_ptr_q      <= '0;
      outstanding_q <= 16'd0;
      w_beat_q      <= 8'd0;
      wr_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      aw_ptr_q      <= aw_ptr_d;
      outstanding_q <= outstanding_d;
      w_beat_q      <= w_beat_d;
      wr_error_q    <= wr_error_d;
    end
  end

endmodule
`default_nettype wire
